// File: rtl/rll_pkg.sv
// Shared types and helpers for the sequential RLL key loader.
// Optional parity build: RLL_KEY_PARITY_EN (the PARITY state is always
// present in the enum so both builds share one encoding).
package rll_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        COMMIT = 2'd3
    } rll_ld_state_e;

    // One key gate: XOR when pol=0, XNOR when pol=1.
    function automatic logic rll_apply_key(input logic net, input logic key, input logic pol);
        return net ^ key ^ pol;
    endfunction

endpackage

// File: rtl/rll_key_gate_bank.sv
// Active-key register plus the registered XOR/XNOR key-gate stage.
// The active key only ever loads a complete shadow word (commit) or is
// wiped (clear), so the locked core never sees a half-updated key.
module rll_key_gate_bank
    import rll_pkg::*;
#(
    parameter int             KEY_W   = 16,
    parameter logic [KEY_W-1:0] KEY_POL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commit,
    input  logic             clear,
    input  logic [KEY_W-1:0] shadow,
    input  logic [KEY_W-1:0] net_in,
    output logic [KEY_W-1:0] net_out
);

    logic [KEY_W-1:0] active;
    logic [KEY_W-1:0] gated;

    // Per-bit key gates driven by the current active key.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        gated = '0;
        for (int i = 0; i < KEY_W; i++) begin
            gated[i] = rll_apply_key(net_in[i], active[i], KEY_POL[i]);
        end
    end

    // Active key register (clear beats commit) and the output register stage.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            active  <= '0;
            net_out <= '0;
        end else begin
            if (clear) begin
                active <= '0;
            end else if (commit) begin
                active <= shadow;
            end
            net_out <= gated;
        end
    end

endmodule

// File: rtl/rll_key_loader.sv
// Serial RLL key loader: shifts the key in LSB first over valid/ready into
// a shadow register, then commits it in one cycle to the gate bank.
// Optional build macro RLL_KEY_PARITY_EN adds a trailing even-parity bit
// and a sticky load_err; without it load_err is tied low.
module rll_key_loader
    import rll_pkg::*;
#(
    parameter int               KEY_W   = 16,
    parameter logic [KEY_W-1:0] KEY_POL = '0,
    localparam int              CNT_W   = $clog2(KEY_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_si,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic             key_abort,
    input  logic             zeroize,
    input  logic [KEY_W-1:0] net_in,
    output logic [KEY_W-1:0] net_out,
    output logic             key_loaded,
    output logic             load_busy,
    output logic             load_err,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(KEY_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    rll_ld_state_e    state, state_d;
    logic [KEY_W-1:0] shadow, shadow_d;
    logic [CNT_W-1:0] cnt_d;
    logic             loaded_d;
    logic             commit, clear;
    logic             xfer;
    logic [KEY_W-1:0] si_vec;

`ifdef RLL_KEY_PARITY_EN
    logic err_q, err_d;
    assign load_err = err_q;
`else
    assign load_err = 1'b0;
`endif

    assign key_ready = (state != COMMIT);
    assign load_busy = (state == SHIFT) || (state == PARITY);
    assign xfer      = key_valid && key_ready;
    assign si_vec    = {{(KEY_W-1){1'b0}}, key_si};

    // Next-state and datapath decode; zeroize overrides whatever the state chose.
    always_comb begin
        state_d  = state;
        shadow_d = shadow;
        cnt_d    = bit_cnt;
        loaded_d = key_loaded;
        commit   = 1'b0;
        clear    = 1'b0;
`ifdef RLL_KEY_PARITY_EN
        err_d    = err_q;
`endif
        case (state)
            IDLE: begin
                if (xfer) begin
                    shadow_d = si_vec;
                    cnt_d    = CNT_ONE;
                    state_d  = SHIFT;
`ifdef RLL_KEY_PARITY_EN
                    err_d    = 1'b0;
`endif
                end
            end
            SHIFT: begin
                if (key_abort) begin
                    shadow_d = '0;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else if (xfer) begin
                    shadow_d = shadow | (si_vec << bit_cnt);
                    cnt_d    = bit_cnt + CNT_ONE;
                    if (cnt_d == CNT_FULL) begin
`ifdef RLL_KEY_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = COMMIT;
`endif
                    end
                end
            end
            PARITY: begin
`ifdef RLL_KEY_PARITY_EN
                if (key_abort) begin
                    shadow_d = '0;
                    cnt_d    = '0;
                    state_d  = IDLE;
                end else if (xfer) begin
                    if (key_si == ^shadow) begin
                        state_d = COMMIT;
                    end else begin
                        shadow_d = '0;
                        cnt_d    = '0;
                        err_d    = 1'b1;
                        state_d  = IDLE;
                    end
                end
`else
                state_d = IDLE;
`endif
            end
            COMMIT: begin
                commit   = 1'b1;
                loaded_d = 1'b1;
                shadow_d = '0;
                cnt_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (zeroize) begin
            state_d  = IDLE;
            shadow_d = '0;
            cnt_d    = '0;
            loaded_d = 1'b0;
            commit   = 1'b0;
            clear    = 1'b1;
`ifdef RLL_KEY_PARITY_EN
            err_d    = err_q;
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Shadow key, bit counter and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow     <= '0;
            bit_cnt    <= '0;
            key_loaded <= 1'b0;
`ifdef RLL_KEY_PARITY_EN
            err_q      <= 1'b0;
`endif
        end else begin
            shadow     <= shadow_d;
            bit_cnt    <= cnt_d;
            key_loaded <= loaded_d;
`ifdef RLL_KEY_PARITY_EN
            err_q      <= err_d;
`endif
        end
    end

    rll_key_gate_bank #(
        .KEY_W   (KEY_W),
        .KEY_POL (KEY_POL)
    ) u_gate_bank (
        .clk     (clk),
        .rst     (rst),
        .commit  (commit),
        .clear   (clear),
        .shadow  (shadow),
        .net_in  (net_in),
        .net_out (net_out)
    );

endmodule

// File: tb/tb_rll_key_loader.sv
// Self-checking bench for rll_key_loader (KEY_W=16, KEY_POL=16'hA5C3).
// The reference model is the key the bench believes is active: every
// cycle net_out must equal last cycle's net_in ^ that key ^ KEY_POL.
module tb_rll_key_loader;

    localparam int          W   = 16;
    localparam logic [15:0] POL = 16'hA5C3;
`ifdef RLL_KEY_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, key_si, key_valid, key_abort, zeroize;
    logic [15:0] net_in;
    logic        key_ready, key_loaded, load_busy, load_err;
    logic [15:0] net_out;
    logic [4:0]  bit_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [15:0] cur_active;
    bit          chk_net;

    rll_key_loader #(.KEY_W(W), .KEY_POL(POL)) dut (
        .clk(clk), .rst(rst), .key_si(key_si), .key_valid(key_valid),
        .key_ready(key_ready), .key_abort(key_abort), .zeroize(zeroize),
        .net_in(net_in), .net_out(net_out), .key_loaded(key_loaded),
        .load_busy(load_busy), .load_err(load_err), .bit_cnt(bit_cnt)
    );

    always #5 clk = ~clk;

    // One clock; checks net_out against the model key active during that cycle.
    task automatic tick();
        logic [15:0] exp;
        exp = net_in ^ cur_active ^ POL;
        @(posedge clk);
        #1;
        cyc++;
        if (chk_net) begin
            n_tests++;
            if (net_out !== exp) begin
                n_fail++;
                $display("FAIL net_out: got %h expected %h (cycle %0d)", net_out, exp, cyc);
            end
        end
    endtask

    // Send n key bits LSB first; gap_mode 0=none, 1=alternate idle, 2=random idles.
    task automatic load_bits(input logic [15:0] key, input int n, input int gap_mode);
        for (int i = 0; i < n; i++) begin
            int gaps;
            gaps = (gap_mode == 1 && i > 0) ? 1 : (gap_mode == 2 ? int'($urandom_range(0, 2)) : 0);
            for (int g = 0; g < gaps; g++) begin
                key_valid = 1'b0;
                key_si    = 1'($urandom);
                net_in    = 16'($urandom);
                tick();
                n_tests++;
                if (bit_cnt !== 5'(i)) begin
                    n_fail++;
                    $display("FAIL gap_cnt: got %0d expected %0d", bit_cnt, i);
                end
            end
            key_valid = 1'b1;
            key_si    = key[i];
            net_in    = 16'($urandom);
            tick();
            key_valid = 1'b0;
            n_tests++;
            if (bit_cnt !== 5'(i + 1)) begin
                n_fail++;
                $display("FAIL load_cnt: got %0d expected %0d", bit_cnt, i + 1);
            end
            n_tests++;
            if (load_busy !== ((i + 1 < W) || PAR)) begin
                n_fail++;
                $display("FAIL load_busy: got %b after bit %0d", load_busy, i);
            end
            n_tests++;
            if (key_ready !== ((i + 1 < W) || PAR)) begin
                n_fail++;
                $display("FAIL load_ready: got %b after bit %0d", key_ready, i);
            end
        end
    endtask

    // After all key bits: optional parity bit, then the COMMIT cycle.
    task automatic finish_load(input logic [15:0] key);
`ifdef RLL_KEY_PARITY_EN
        key_valid = 1'b1;
        key_si    = ^key;
        tick();
        key_valid = 1'b0;
`endif
        n_tests++;
        if (key_ready !== 1'b0 || bit_cnt !== 5'd16) begin
            n_fail++;
            $display("FAIL commit_state: ready=%b cnt=%0d expected ready=0 cnt=16", key_ready, bit_cnt);
        end
        key_valid = 1'b1;
        key_si    = 1'($urandom);
        tick();
        key_valid = 1'b0;
        cur_active = key;
        n_tests++;
        if (key_loaded !== 1'b1 || bit_cnt !== 5'd0 || load_busy !== 1'b0 || key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_commit: loaded=%b cnt=%0d busy=%b ready=%b expected 1 0 0 1",
                     key_loaded, bit_cnt, load_busy, key_ready);
        end
        n_tests++;
        if (load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL commit_err: got %b expected 0", load_err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; key_si = 1'b0; key_valid = 1'b0; key_abort = 1'b0; zeroize = 1'b0;
        net_in = 16'h0000; chk_net = 1'b0; cur_active = 16'h0000;
        tick(); tick();
        n_tests++;
        if (net_out !== 16'h0000 || bit_cnt !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_data: net_out=%h cnt=%0d expected 0000 0", net_out, bit_cnt);
        end
        n_tests++;
        if (key_ready !== 1'b1 || key_loaded !== 1'b0 || load_busy !== 1'b0 || load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: ready=%b loaded=%b busy=%b err=%b expected 1 0 0 0",
                     key_ready, key_loaded, load_busy, load_err);
        end
        rst = 1'b0; chk_net = 1'b1;
        tick();
        n_tests++;
        if (net_out !== 16'hA5C3 || key_ready !== 1'b1 || key_loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: net_out=%h ready=%b loaded=%b expected a5c3 1 0",
                     net_out, key_ready, key_loaded);
        end
    endtask

    task automatic test_serial_load();
        int c0;
        c0 = cyc;
        load_bits(16'h1234, 16, 0);
        n_tests++;
        if (cyc - c0 !== 16) begin
            n_fail++;
            $display("FAIL serial_cycles: got %0d expected 16", cyc - c0);
        end
        finish_load(16'h1234);
        net_in = 16'h0000;
        tick();
        n_tests++;
        if (net_out !== 16'hB7F7) begin
            n_fail++;
            $display("FAIL serial_net: got %h expected b7f7", net_out);
        end
    endtask

    task automatic test_abort();
        load_bits(16'hFFFF, 8, 0);
        key_abort = 1'b1; key_valid = 1'b1; key_si = 1'b1; net_in = 16'h0000;
        tick();
        key_abort = 1'b0; key_valid = 1'b0;
        n_tests++;
        if (bit_cnt !== 5'd0 || load_busy !== 1'b0 || key_loaded !== 1'b1 || key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_state: cnt=%0d busy=%b loaded=%b ready=%b expected 0 0 1 1",
                     bit_cnt, load_busy, key_loaded, key_ready);
        end
        tick();
        n_tests++;
        if (net_out !== 16'hB7F7) begin
            n_fail++;
            $display("FAIL abort_net: got %h expected b7f7", net_out);
        end
        // Abort in IDLE has no effect: the coincident transfer still starts a load.
        key_abort = 1'b1; key_valid = 1'b1; key_si = 1'b1;
        tick();
        key_abort = 1'b0; key_valid = 1'b0;
        n_tests++;
        if (bit_cnt !== 5'd1 || load_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_abort: cnt=%0d busy=%b expected 1 1", bit_cnt, load_busy);
        end
        key_abort = 1'b1;
        tick();
        key_abort = 1'b0;
    endtask

    task automatic test_zeroize();
        load_bits(16'($urandom), 5, 0);
        zeroize = 1'b1; key_abort = 1'b1; key_valid = 1'b1; key_si = 1'b1;
        tick();
        zeroize = 1'b0; key_abort = 1'b0; key_valid = 1'b0;
        cur_active = 16'h0000;
        n_tests++;
        if (key_loaded !== 1'b0 || bit_cnt !== 5'd0 || key_ready !== 1'b1 || load_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zeroize_state: loaded=%b cnt=%0d ready=%b busy=%b expected 0 0 1 0",
                     key_loaded, bit_cnt, key_ready, load_busy);
        end
        net_in = 16'h0000;
        tick();
        n_tests++;
        if (net_out !== 16'hA5C3) begin
            n_fail++;
            $display("FAIL zeroize_net: got %h expected a5c3", net_out);
        end
        // Zeroize landing on the COMMIT cycle must suppress the commit.
        load_bits(16'hBEEF, 16, 0);
`ifdef RLL_KEY_PARITY_EN
        key_valid = 1'b1; key_si = ^16'hBEEF;
        tick();
        key_valid = 1'b0;
`endif
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        n_tests++;
        if (key_loaded !== 1'b0 || bit_cnt !== 5'd0) begin
            n_fail++;
            $display("FAIL zeroize_commit: loaded=%b cnt=%0d expected 0 0", key_loaded, bit_cnt);
        end
        net_in = 16'($urandom);
        tick();
    endtask

    task automatic test_gap_toggle();
        int c0;
        c0 = cyc;
        load_bits(16'h1234, 16, 1);
        n_tests++;
        if (cyc - c0 !== 31) begin
            n_fail++;
            $display("FAIL gap_cycles: got %0d expected 31", cyc - c0);
        end
        finish_load(16'h1234);
        net_in = 16'h0000;
        tick();
        n_tests++;
        if (net_out !== 16'hB7F7) begin
            n_fail++;
            $display("FAIL gap_net: got %h expected b7f7", net_out);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ka, kb;
        ka = 16'($urandom);
        kb = 16'($urandom);
        load_bits(ka, 16, 0);
        finish_load(ka);
        load_bits(kb, 16, 2);
        finish_load(kb);
        for (int i = 0; i < 3; i++) begin
            net_in = 16'($urandom);
            tick();
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            logic [15:0] k;
            int          act, n;
            k   = 16'($urandom);
            act = int'($urandom_range(0, 2));
            n   = (act == 0) ? W : int'($urandom_range(1, W - 1));
            load_bits(k, n, int'($urandom_range(0, 2)));
            if (act == 0) begin
                finish_load(k);
            end else if (act == 1) begin
                key_abort = 1'b1;
                tick();
                key_abort = 1'b0;
                n_tests++;
                if (bit_cnt !== 5'd0 || key_loaded !== (cur_active != 16'h0000)) begin
                    n_fail++;
                    $display("FAIL rand_abort: cnt=%0d loaded=%b", bit_cnt, key_loaded);
                end
            end else begin
                zeroize = 1'b1;
                tick();
                zeroize = 1'b0;
                cur_active = 16'h0000;
                n_tests++;
                if (bit_cnt !== 5'd0 || key_loaded !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rand_zeroize: cnt=%0d loaded=%b expected 0 0", bit_cnt, key_loaded);
                end
            end
            for (int i = 0; i < 2; i++) begin
                net_in = 16'($urandom);
                tick();
            end
        end
    endtask

`ifdef RLL_KEY_PARITY_EN
    task automatic test_parity();
        logic loaded0;
        loaded0 = key_loaded;
        load_bits(16'h0001, 16, 0);
        key_valid = 1'b1; key_si = 1'b0;
        tick();
        key_valid = 1'b0;
        n_tests++;
        if (load_err !== 1'b1 || key_ready !== 1'b1 || load_busy !== 1'b0 ||
            bit_cnt !== 5'd0 || key_loaded !== loaded0) begin
            n_fail++;
            $display("FAIL parity_bad: err=%b ready=%b busy=%b cnt=%0d loaded=%b",
                     load_err, key_ready, load_busy, bit_cnt, key_loaded);
        end
        tick();
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        cur_active = 16'h0000;
        n_tests++;
        if (load_err !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_zeroize_err: got %b expected 1", load_err);
        end
        load_bits(16'h0001, 1, 0);
        n_tests++;
        if (load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_err_clear: got %b expected 0", load_err);
        end
        key_abort = 1'b1;
        tick();
        key_abort = 1'b0;
        load_bits(16'h0001, 16, 0);
        finish_load(16'h0001);
        net_in = 16'h0000;
        tick();
        n_tests++;
        if (net_out !== 16'hA5C2) begin
            n_fail++;
            $display("FAIL parity_net: got %h expected a5c2", net_out);
        end
    endtask
`endif

    task automatic test_reset_midload();
        load_bits(16'($urandom), 6, 0);
        rst = 1'b1; chk_net = 1'b0;
        tick();
        rst = 1'b0;
        cur_active = 16'h0000;
        n_tests++;
        if (bit_cnt !== 5'd0 || load_busy !== 1'b0 || key_loaded !== 1'b0 || net_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_midload: cnt=%0d busy=%b loaded=%b net=%h expected 0 0 0 0000",
                     bit_cnt, load_busy, key_loaded, net_out);
        end
        chk_net = 1'b1;
        net_in = 16'h0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_serial_load();
        test_abort();
        test_zeroize();
        test_gap_toggle();
        test_back_to_back();
        test_random();
`ifdef RLL_KEY_PARITY_EN
        test_parity();
`endif
        test_reset_midload();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
